cpu_phase_sequencer: RTL and testbench

- Multi-cycle phase controller for the RISC-V core.
- Generates the 2-bit `state` phase that the main control decoder samples on `state == 1`.
- Owns the instruction-memory and data-memory request handshakes, plus the IR/PC/register-file write strobes.
- Sits between the fetch unit, main control, the memories and the register file. It halts on ECALL, on an illegal opcode, or on a memory timeout.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/cpu_phase_sequencer.sv | 157 +++++++++++++++
 tb/tb_cpu_phase_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcode constants, control phases
// and the phase sequencer state encoding.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PH_FETCH  = 2'd0;
  localparam logic [1:0] PH_DECODE = 2'd1;
  localparam logic [1:0] PH_EXEC   = 2'd2;
  localparam logic [1:0] PH_WB     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } seq_state_e;

  // IDLE and HALT report FETCH so main control never sees a spurious DECODE.
  function automatic logic [1:0] phase_of(input seq_state_e s);
    case (s)
      ST_DECODE:      phase_of = PH_DECODE;
      ST_EXEC:        phase_of = PH_EXEC;
      ST_MEM:         phase_of = PH_EXEC;
      ST_WB:          phase_of = PH_WB;
      default:        phase_of = PH_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready request cycles; expired flags the cycle that
// would complete MAX_WAIT waits.
module mem_wait_timer #(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = enable && !clear && (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle phase controller: sequences FETCH/DECODE/EXEC/MEM/WB, owns the
// memory request handshakes and IR/PC/regfile strobes, and halts on error.
// Handshake: a request stays high every cycle of its phase; the cycle its ready
// is seen completes it, and a ready with no request outstanding is ignored.
module cpu_phase_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic [1:0]       state,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             reg_commit,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  seq_state_e       state_q, state_d;
  logic             is_load_q, is_load_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             wait_clear, wait_en, wait_expired;

  assign wait_en    = ((state_q == ST_FETCH) && !imem_ready) ||
                      ((state_q == ST_MEM)   && !dmem_ready);
  assign wait_clear = !wait_en;

  mem_wait_timer #(.WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wait_clear),
    .enable  (wait_en),
    .expired (wait_expired)
  );

  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    retired_d  = retired_q;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_req   = 1'b0;
    pc_write   = 1'b0;
    reg_commit = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM: state_d = ST_EXEC;
          OP_SYSTEM: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
        endcase
      end
      ST_EXEC: begin
        case (opcode)
          OP_R, OP_IMM: state_d = ST_WB;
          OP_LOAD, OP_STORE: begin
            // Remember the direction so MEM ignores later opcode changes.
            is_load_d = (opcode == OP_LOAD);
            state_d   = ST_MEM;
          end
          OP_BRANCH: begin
            pc_write  = 1'b1;
            retired_d = retired_q + 1'b1;
            state_d   = ST_FETCH;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          if (is_load_q) begin
            state_d = ST_WB;
          end else begin
            pc_write  = 1'b1;
            retired_d = retired_q + 1'b1;
            state_d   = ST_FETCH;
          end
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_WB: begin
        reg_commit = 1'b1;
        pc_write   = 1'b1;
        retired_d  = retired_q + 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      is_load_q <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  assign state   = phase_of(state_q);
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench: a program-level model expands each instruction into its
// per-cycle inputs and expected outputs; one process drives, one compares.
module tb_cpu_phase_sequencer;
  import cpu_pkg::*;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 200;
  localparam int OW       = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [6:0]       opcode = '0;
  logic             imem_ready = 1'b0;
  logic             dmem_ready = 1'b0;
  logic [1:0]       state;
  logic             imem_req, ir_write, dmem_req, pc_write, reg_commit;
  logic             busy, halted, illegal, timeout;
  logic [CNT_W-1:0] retired;

  cpu_phase_sequencer #(.CNT_W(CNT_W), .WAIT_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .state(state),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req),
    .pc_write(pc_write), .reg_commit(reg_commit), .busy(busy),
    .halted(halted), .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [10:0]   stim_q[$];
  logic [OW-1:0] exp_q[$];
  int            chk_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  logic             m_halted, m_illegal, m_timeout;
  logic [CNT_W-1:0] m_retired;
  int               pending_chk = -1;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic bit is_valid(input logic [6:0] op);
    return op == OP_R || op == OP_LOAD || op == OP_STORE || op == OP_BRANCH || op == OP_IMM;
  endfunction

  task automatic check_lit(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // One cycle of stimulus plus the outputs the spec requires during it.
  task automatic emit(input bit rst, input bit st, input logic [6:0] op, input bit ir_rdy,
                      input bit d_rdy, input logic [1:0] ph, input bit imr, input bit irw,
                      input bit dmr, input bit pcw, input bit rc, input bit bsy);
    stim_q.push_back({rst, st, op, ir_rdy, d_rdy});
    exp_q.push_back({ph, imr, irw, dmr, pcw, rc, bsy, m_halted, m_illegal, m_timeout, m_retired});
    chk_q.push_back(pending_chk);
    pending_chk = -1;
  endtask

  task automatic do_reset();
    m_halted = 0; m_illegal = 0; m_timeout = 0; m_retired = '0;
    emit(0, rb(), junk(), rb(), rb(), 2'd0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle_start();
    emit(1, 0, junk(), rb(), rb(), 2'd0, 0, 0, 0, 0, 0, 0);
    emit(1, 1, junk(), rb(), rb(), 2'd0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) emit(1, 1, junk(), rb(), rb(), 2'd0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wb_cycle();
    emit(1, rb(), junk(), rb(), rb(), 2'd3, 0, 0, 0, 1, 1, 1);
    m_retired++;
  endtask

  // Whole instruction at program level; a wait >= MAX_WAIT means "never ready".
  task automatic instr(input logic [6:0] op, input int iwait, input int dwait,
                       input bit cut_in_mem, output int cycles);
    int c0 = exp_q.size();
    int n;
    n = (iwait >= MAX_WAIT) ? MAX_WAIT : iwait;
    for (int i = 0; i < n; i++) emit(1, rb(), junk(), 0, rb(), 2'd0, 1, 0, 0, 0, 0, 1);
    if (iwait >= MAX_WAIT) begin
      m_timeout = 1; cycles = exp_q.size() - c0; return;
    end
    emit(1, rb(), junk(), 1, rb(), 2'd0, 1, 1, 0, 0, 0, 1);
    emit(1, rb(), op, rb(), rb(), 2'd1, 0, 0, 0, 0, 0, 1);
    if (!is_valid(op)) begin
      if (op == OP_SYSTEM) m_halted = 1;
      else m_illegal = 1;
      cycles = exp_q.size() - c0; return;
    end
    if (op == OP_BRANCH) begin
      emit(1, rb(), op, rb(), rb(), 2'd2, 0, 0, 0, 1, 0, 1);
      m_retired++;
      cycles = exp_q.size() - c0; return;
    end
    emit(1, rb(), op, rb(), rb(), 2'd2, 0, 0, 0, 0, 0, 1);
    if (op == OP_LOAD || op == OP_STORE) begin
      n = (dwait >= MAX_WAIT) ? MAX_WAIT : dwait;
      for (int i = 0; i < n; i++) begin
        emit(1, rb(), junk(), rb(), 0, 2'd2, 0, 0, 1, 0, 0, 1);
        if (cut_in_mem && i == n - 1) begin
          cycles = exp_q.size() - c0; return;
        end
      end
      if (dwait >= MAX_WAIT) begin
        m_timeout = 1; cycles = exp_q.size() - c0; return;
      end
      if (op == OP_STORE) begin
        emit(1, rb(), junk(), rb(), 1, 2'd2, 0, 0, 1, 1, 0, 1);
        m_retired++;
        cycles = exp_q.size() - c0; return;
      end
      emit(1, rb(), junk(), rb(), 1, 2'd2, 0, 0, 1, 0, 0, 1);
    end
    wb_cycle();
    cycles = exp_q.size() - c0;
  endtask

  task automatic build_program();
    int c;
    do_reset();
    idle_start();
    instr(OP_R, 0, 0, 0, c);      check_lit("lat_r", c, 4);
    instr(OP_IMM, 0, 0, 0, c);    check_lit("lat_imm", c, 4);
    pending_chk = 2;
    instr(OP_LOAD, 0, 3, 0, c);   check_lit("lat_load_wait3", c, 8);
    pending_chk = 3;
    instr(OP_STORE, 0, 0, 0, c);  check_lit("lat_store", c, 4);
    instr(OP_BRANCH, 0, 0, 0, c); check_lit("lat_branch", c, 3);
    pending_chk = 5;
    instr(OP_LOAD, 0, 0, 0, c);   check_lit("lat_load", c, 5);
    instr(OP_R, 2, 0, 0, c);
    instr(7'b1111111, 0, 0, 0, c);
    halt_cycles(3);
    do_reset();
    idle_start();
    instr(OP_R, 1000, 0, 0, c);   check_lit("lat_fetch_timeout", c, MAX_WAIT);
    halt_cycles(2);
    do_reset();
    idle_start();
    instr(OP_SYSTEM, 1, 0, 0, c);
    halt_cycles(2);
    do_reset();
    idle_start();
    for (int i = 0; i < 14; i++) instr(OP_BRANCH, 0, 0, 0, c);
    pending_chk = 14;
    instr(OP_LOAD, 0, 5, 1, c);
    do_reset();
    idle_start();
    for (int i = 0; i < 15; i++) instr(OP_BRANCH, 0, 0, 0, c);
    pending_chk = 15;
    instr(OP_R, 0, 0, 0, c);
    pending_chk = 0;
    instr(OP_STORE, 0, 1000, 0, c);
    halt_cycles(2);
  endtask

  initial begin
    build_program();
    fork
      begin : driver
        for (int i = 0; i < stim_q.size(); i++) begin
          @(posedge clk);
          #1;
          {rst_n, start, opcode, imem_ready, dmem_ready} = stim_q[i];
        end
      end
      begin : scoreboard
        logic [OW-1:0] got;
        for (int i = 0; i < exp_q.size(); i++) begin
          @(negedge clk);
          got = {state, imem_req, ir_write, dmem_req, pc_write, reg_commit, busy,
                 halted, illegal, timeout, retired};
          n_checks++;
          if (got !== exp_q[i]) begin
            n_fail++;
            $display("FAIL cyc%0d {ph,imr,irw,dmr,pcw,rc,busy,hlt,ill,to,ret}: got %b expected %b",
                     i, got, exp_q[i]);
          end
          if (chk_q[i] >= 0) begin
            n_checks++;
            if (int'(retired) != chk_q[i]) begin
              n_fail++;
              $display("FAIL retired_checkpoint cyc%0d: got %0d expected %0d", i, retired, chk_q[i]);
            end
          end
        end
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
